seq_det_prog_ctrl: RTL and testbench

Programmable serial-pattern detection controller that configures, arms, runs and stops a bit-stream detector.
- Replaces fixed-pattern detectors such as the 101 Moore detector with one runtime-configurable block: pattern, length, overlap mode.
- Sits between the control/register interface and the serial input stream.
- Counts matches and emits a registered one-cycle match pulse.

---
 rtl/seq_det_prog_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seq_det_prog_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog_ctrl.sv
// seq_det_prog_ctrl: runtime-programmable serial pattern detector controller.
// Flow: configure (pattern, length, overlap mode), arm, run, stop.
// The detector counts matches and emits a registered one-cycle match pulse.
// Optional feature macro: SEQ_DET_TIMEOUT_EN. When it is defined, the block
// gains parameter TIMEOUT and a timeout pulse output. A run of TIMEOUT idle
// input cycles in RUN then discards the partially received bits.
module seq_det_prog_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
`ifdef SEQ_DET_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    output logic               out,
    output logic               busy,
    output logic [CNT_W-1:0]   match_cnt,
`ifdef SEQ_DET_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               cnt_sat
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t             state_reg, state_next;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    // Only the newest MAX_LEN-1 bits need storing; the incoming bit completes the window.
    logic [MAX_LEN-2:0] history_reg;
    logic [MAX_LEN-1:0] history_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_reg, fill_inc;
    logic [CNT_W-1:0]   cnt_reg;
    logic               cnt_sat_reg, out_reg, cfg_err_reg;
    logic               cfg_fire, cfg_ok, start_fire, run_step, match;

    assign cfg_ready    = (state_reg != RUN);
    assign cfg_fire     = cfg_valid & cfg_ready;
    assign cfg_ok       = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
    assign start_fire   = (state_reg == ARMED) & start & ~stop;
    assign run_step     = (state_reg == RUN) & in_valid & ~stop;
    assign history_next = {history_reg, in};
    assign fill_inc     = (fill_reg >= MAX_LEN_V) ? MAX_LEN_V : fill_reg + 1'b1;

    // Compare only the low len bits of the window: bit gi takes part when gi < len.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

    assign match = run_step && (fill_inc >= len_reg) &&
                   (((history_next ^ pattern_reg) & len_mask) == '0);

    assign out       = out_reg;
    assign busy      = (state_reg == RUN);
    assign match_cnt = cnt_reg;
    assign cnt_sat   = cnt_sat_reg;
    assign cfg_err   = cfg_err_reg;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_reg;
    logic            to_hit;

    assign to_hit  = (state_reg == RUN) & ~stop & ~in_valid & (to_cnt_reg == TO_W'(TIMEOUT - 1));
    assign timeout = timeout_reg;

    // Idle-cycle counter: restarts on any valid bit, on leaving RUN, and on each expiry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= to_hit;
            if ((state_reg != RUN) || stop || in_valid || to_hit)
                to_cnt_reg <= '0;
            else
                to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`endif

    // Next-state logic: stop overrides everything; IDLE needs a valid config to arm.
    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (cfg_fire && cfg_ok) state_next = ARMED;
                ARMED:   if (start) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Config registers: accepted configs replace the stored one; rejects only pulse cfg_err.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern_reg <= '0;
            len_reg     <= '0;
            overlap_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_fire & ~cfg_ok;
            if (cfg_fire && cfg_ok) begin
                pattern_reg <= cfg_pattern;
                len_reg     <= cfg_len;
                overlap_reg <= cfg_overlap;
            end
        end
    end

    // Shift history on each valid bit in RUN; non-overlap mode restarts the fill after a match.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            history_reg <= '0;
            fill_reg    <= '0;
            out_reg     <= 1'b0;
        end else begin
            out_reg <= match;
            if (start_fire) begin
                history_reg <= '0;
                fill_reg    <= '0;
            end else if (run_step) begin
                history_reg <= history_next[MAX_LEN-2:0];
                fill_reg    <= (match && !overlap_reg) ? '0 : fill_inc;
            end
`ifdef SEQ_DET_TIMEOUT_EN
            else if (to_hit) begin
                fill_reg <= '0;
            end
`endif
        end
    end

    // Saturating match counter; the sticky flag sets on the match that reaches the maximum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg     <= '0;
            cnt_sat_reg <= 1'b0;
        end else if (start_fire) begin
            cnt_reg     <= '0;
            cnt_sat_reg <= 1'b0;
        end else if (match && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_MAX - 1'b1) cnt_sat_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_prog_ctrl.sv
// Directed self-checking bench for seq_det_prog_ctrl (MAX_LEN=8, CNT_W=2).
module tb_seq_det_prog_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cfg_err;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       out;
    logic       busy;
    logic [1:0] match_cnt;
    logic       cnt_sat;
`ifdef SEQ_DET_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    seq_det_prog_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .start(start), .stop(stop), .in(in), .in_valid(in_valid),
        .out(out), .busy(busy), .match_cnt(match_cnt),
`ifdef SEQ_DET_TIMEOUT_EN
        .timeout(timeout),
`endif
        .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "bench did not finish");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        in = b; in_valid = 1'b1; cycle(); in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b exp 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (match_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", match_cnt); end
        checks++; if (cnt_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", cnt_sat); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
        rstn = 1'b1;
        cycle();
        $display("reset: out=%b busy=%b cnt=%0d ready=%b", out, busy, match_cnt, cfg_ready);
    endtask

    task automatic test_overlap();
        logic       bits[5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       exp_out[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_cnt[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        do_cfg(8'b101, 4'd3, 1'b1);
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL ovl_armed got busy=%b ready=%b exp busy=0 ready=1", busy, cfg_ready); end
        do_start();
        checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL ovl_run got busy=%b ready=%b exp busy=1 ready=0", busy, cfg_ready); end
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[i]);
            $display("overlap bit%0d=%b out=%b cnt=%0d", i, bits[i], out, match_cnt);
            checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL ovl_out bit%0d got %b exp %b", i, out, exp_out[i]); end
            checks++; if (match_cnt !== exp_cnt[i]) begin errors++; $display("FAIL ovl_cnt bit%0d got %0d exp %0d", i, match_cnt, exp_cnt[i]); end
        end
        cycle();
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL ovl_pulse_width got %b exp 0", out); end
        do_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovl_stop_busy got %b exp 0", busy); end
    endtask

    task automatic test_nonoverlap();
        logic bits[5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic exp_out[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_cfg(8'b101, 4'd3, 1'b0);
        do_start();
        checks++; if (match_cnt !== 2'd0) begin errors++; $display("FAIL nov_start_cnt got %0d exp 0", match_cnt); end
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[i]);
            $display("nonoverlap bit%0d=%b out=%b cnt=%0d", i, bits[i], out, match_cnt);
            checks++; if (out !== exp_out[i]) begin errors++; $display("FAIL nov_out bit%0d got %b exp %b", i, out, exp_out[i]); end
        end
        checks++; if (match_cnt !== 2'd1) begin errors++; $display("FAIL nov_cnt got %0d exp 1", match_cnt); end
        do_stop();
    endtask

    task automatic test_cfg_err();
        logic [3:0] bad_len[2] = '{4'd0, 4'd9};
        for (int i = 0; i < 2; i++) begin
            do_cfg(8'b101, bad_len[i], 1'b1);
            $display("cfg_err len=%0d err=%b ready=%b busy=%b", bad_len[i], cfg_err, cfg_ready, busy);
            checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse len%0d got %b exp 1", bad_len[i], cfg_err); end
            cycle();
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_width len%0d got %b exp 0", bad_len[i], cfg_err); end
        end
        do_start();
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_err_idle got busy=%b ready=%b exp busy=0 ready=1", busy, cfg_ready); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       exp_sat[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_cfg(8'b1, 4'd1, 1'b1);
        do_start();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            $display("sat bit%0d out=%b cnt=%0d sat=%b", i, out, match_cnt, cnt_sat);
            checks++; if (match_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt bit%0d got %0d exp %0d", i, match_cnt, exp_cnt[i]); end
            checks++; if (cnt_sat !== exp_sat[i]) begin errors++; $display("FAIL sat_flag bit%0d got %b exp %b", i, cnt_sat, exp_sat[i]); end
            checks++; if (out !== 1'b1) begin errors++; $display("FAIL sat_out bit%0d got %b exp 1", i, out); end
        end
        do_cfg(8'b1, 4'd0, 1'b1);
        checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_cfg_ignored got err=%b busy=%b exp err=0 busy=1", cfg_err, busy); end
        do_stop();
        do_cfg(8'b1, 4'd1, 1'b1);
        checks++; if (match_cnt !== 2'd3 || cnt_sat !== 1'b1) begin errors++; $display("FAIL sat_hold got cnt=%0d sat=%b exp cnt=3 sat=1", match_cnt, cnt_sat); end
        do_start();
        checks++; if (match_cnt !== 2'd0 || cnt_sat !== 1'b0) begin errors++; $display("FAIL sat_clear got cnt=%0d sat=%b exp cnt=0 sat=0", match_cnt, cnt_sat); end
        do_stop();
    endtask

    task automatic test_stop_on_match();
        do_cfg(8'b101, 4'd3, 1'b1);
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        in = 1'b1; in_valid = 1'b1; stop = 1'b1;
        cycle();
        in_valid = 1'b0; stop = 1'b0;
        $display("stop_on_match out=%b cnt=%0d busy=%b ready=%b", out, match_cnt, busy, cfg_ready);
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL stop_out got %b exp 0", out); end
        checks++; if (match_cnt !== 2'd0) begin errors++; $display("FAIL stop_cnt got %0d exp 0", match_cnt); end
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_state got busy=%b ready=%b exp busy=0 ready=1", busy, cfg_ready); end
        do_start();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_restart got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        do_cfg(8'b101, 4'd3, 1'b1);
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++; if (out !== 1'b1 || match_cnt !== 2'd1) begin errors++; $display("FAIL rst_pre got out=%b cnt=%0d exp out=1 cnt=1", out, match_cnt); end
        rstn = 1'b0;
        #1;
        $display("reset_mid_run out=%b busy=%b cnt=%0d ready=%b", out, busy, match_cnt, cfg_ready);
        checks++; if (out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got out=%b busy=%b exp out=0 busy=0", out, busy); end
        checks++; if (match_cnt !== 2'd0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_async_cnt got cnt=%0d ready=%b exp cnt=0 ready=1", match_cnt, cfg_ready); end
        #3 rstn = 1'b1;
        cycle();
        do_start();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_noconfig got busy=%b exp 0", busy); end
        send_bit(1'b1);
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL rst_idle_bit got out=%b exp 0", out); end
        do_cfg(8'b101, 4'd3, 1'b1);
        do_start();
        send_bit(1'b1);
        checks++; if (out !== 1'b0 || match_cnt !== 2'd0) begin errors++; $display("FAIL rst_fresh got out=%b cnt=%0d exp out=0 cnt=0", out, match_cnt); end
        send_bit(1'b0);
        send_bit(1'b1);
        checks++; if (out !== 1'b1) begin errors++; $display("FAIL rst_rematch got out=%b exp 1", out); end
        do_stop();
    endtask

    task automatic test_gaps();
        do_cfg(8'b101, 4'd3, 1'b0);
        do_start();
        send_bit(1'b1);
        repeat (3) cycle();
        send_bit(1'b0);
        repeat (2) cycle();
        send_bit(1'b1);
        $display("gaps out=%b cnt=%0d", out, match_cnt);
        checks++; if (out !== 1'b1 || match_cnt !== 2'd1) begin errors++; $display("FAIL gap_match got out=%b cnt=%0d exp out=1 cnt=1", out, match_cnt); end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_cfg_err();
        test_saturation();
        test_stop_on_match();
        test_reset_mid_run();
        test_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
